if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_pkg.sv | 31 +++
 rtl/fetch_fifo.sv | 75 +++++++
 rtl/if_stage.sv | 140 ++++++++++++++
 tb/tb_if_stage.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared types, constants and helpers for the instruction fetch stage
package if_pkg;

  // Fetch sequencer states: IDLE may issue, WAIT owns a live request,
  // DROP owns a request whose data must be thrown away.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_t;

  // Bubble presented downstream when no instruction is available.
  localparam logic [31:0] NOP = 32'h0000_0000;

  // First fetch address after reset unless overridden.
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // One buffer entry is {pc+4, instruction}.
  localparam int ENTRY_W = 64;

  // Sequential PC; wraps naturally at the top of the address space.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  // Instruction fetches are always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small prefetch buffer holding {pc+4, instruction} entries
module fetch_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = ENTRY_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign full      = (count == DEPTH_C);
  assign head_data = mem[rd_ptr];

  // Pops need data present, pushes need room (a same-cycle pop frees a slot); flush overrides both.
  always_comb begin
    do_pop  = pop && (count != '0) && !flush;
    do_push = push && (!full || do_pop) && !flush;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      if (do_push) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are only visible through count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with single outstanding request and prefetch buffer
module if_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  output logic [31:0] out_pc4,
  output logic [31:0] out_instr
);

  localparam int CW = $clog2(BUF_DEPTH + 1);

  fetch_state_t       state;
  fetch_state_t       state_nxt;
  logic [31:0]        fpc;
  logic [31:0]        req_addr;
  logic               req_raw;
  logic               issue;
  logic               advance;
  logic               buf_push;
  logic               buf_pop;
  logic               buf_full;
  logic [CW-1:0]      buf_count;
  logic [ENTRY_W-1:0] buf_push_data;
  logic [ENTRY_W-1:0] buf_head;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus request/push decisions. Issuing only when the buffer is
  // not full reserves the slot, so a completed fetch always has room.
  always_comb begin
    state_nxt = state;
    req_raw   = 1'b0;
    issue     = 1'b0;
    advance   = 1'b0;
    buf_push  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!buf_full && !redirect) begin
          req_raw   = 1'b1;
          issue     = 1'b1;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        req_raw = 1'b1;
        if (imem_ack) begin
          state_nxt = ST_IDLE;
          // A redirect landing with the data makes that data stale.
          if (!redirect) begin
            buf_push = 1'b1;
            advance  = 1'b1;
          end
        end else if (redirect) begin
          state_nxt = ST_DROP;
        end
      end
      ST_DROP: begin
        // The memory still owes us a response; keep asking until it arrives, then discard it.
        req_raw = 1'b1;
        if (imem_ack) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Request address: live fetch PC while idle, latched address while a request is in flight.
  always_comb begin
    imem_req  = req_raw && !rst;
    imem_addr = (state == ST_IDLE) ? fpc : req_addr;
  end

  // Fetch PC and in-flight request address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc      <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      if (redirect) begin
        fpc <= word_align(redirect_pc);
      end else if (advance) begin
        fpc <= pc_plus4(fpc);
      end
      if (issue) begin
        req_addr <= fpc;
      end
    end
  end

  // Buffer control: redirect flushes and suppresses both push and pop.
  always_comb begin
    buf_push_data = {pc_plus4(fpc), imem_rdata};
    buf_pop       = out_valid && !stall && !redirect;
  end

  fetch_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fetch_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (buf_push),
    .push_data (buf_push_data),
    .pop       (buf_pop),
    .head_data (buf_head),
    .count     (buf_count),
    .full      (buf_full)
  );

  // Present the buffer head, or a NOP bubble when empty.
  always_comb begin
    out_valid = (buf_count != '0);
    out_pc4   = out_valid ? buf_head[63:32] : NOP;
    out_instr = out_valid ? buf_head[31:0]  : NOP;
  end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        out_valid;
  logic [31:0] out_pc4;
  logic [31:0] out_instr;

  logic        imem_req2;
  logic [31:0] imem_addr2;
  logic        imem_ack2 = 1'b0;
  logic [31:0] imem_rdata2 = 32'h0;
  logic        out_valid2;
  logic [31:0] out_pc42;
  logic [31:0] out_instr2;

  int checks = 0;
  int errors = 0;

  bit auto_mem = 1'b1;
  int lat = 1;
  int age = 0;
  int age2 = 0;

  logic [63:0] mq[$];
  logic [31:0] m_fpc = 32'h0;
  logic [31:0] m_addr = 32'h0;
  bit          m_busy = 1'b0;
  bit          m_drop = 1'b0;
  bit          m_valid;
  bit          m_issue;

  logic        e_valid;
  logic        e_req;
  logic [31:0] e_addr;
  logic [63:0] e_head;

  if_stage #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) u_dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_pc4(out_pc4), .out_instr(out_instr)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC), .BUF_DEPTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .stall(1'b0), .redirect(1'b0), .redirect_pc(32'h0),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack2), .imem_rdata(imem_rdata2),
    .out_valid(out_valid2), .out_pc4(out_pc42), .out_instr(out_instr2)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return ~addr;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance n cycles; the auto memory answers a request lat cycles after it first appears.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      #1;
      if (auto_mem) begin
        if (imem_req) begin
          if (age >= lat) begin
            imem_ack   = 1'b1;
            imem_rdata = mem_word(imem_addr);
            age        = 0;
          end else begin
            imem_ack = 1'b0;
            age++;
          end
        end else begin
          imem_ack = 1'b0;
          age      = 0;
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    #1;
    while (!imem_req && n < 20) begin
      run(1);
      n++;
    end
    if (!imem_req) begin
      checks++;
      errors++;
      $display("FAIL wait_req: imem_req still 0 after 20 cycles, required 1");
    end
  endtask

  // Memory for the second instance: one-cycle latency, always on.
  initial forever begin
    @(posedge clk);
    #2;
    if (rst || !imem_req2) begin
      imem_ack2 = 1'b0;
      age2      = 0;
    end else if (age2 >= 1) begin
      imem_ack2   = 1'b1;
      imem_rdata2 = mem_word(imem_addr2);
      age2        = 0;
    end else begin
      imem_ack2 = 1'b0;
      age2++;
    end
  end

  // Reference model: queue of fetched {pc+4, instr}, next fetch pc, one outstanding request.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      mq.delete();
      m_fpc  = 32'h0;
      m_busy = 1'b0;
      m_drop = 1'b0;
    end else begin
      m_valid = (mq.size() != 0);
      m_issue = !m_busy && (mq.size() < 2) && !redirect;
      if (m_valid && !stall && !redirect) void'(mq.pop_front());
      if (m_busy && imem_ack) begin
        if (!m_drop && !redirect) begin
          mq.push_back({m_addr + 32'd4, imem_rdata});
          m_fpc = m_addr + 32'd4;
        end
        m_busy = 1'b0;
      end else if (m_busy && redirect) begin
        m_drop = 1'b1;
      end
      if (m_issue) begin
        m_busy = 1'b1;
        m_drop = 1'b0;
        m_addr = m_fpc;
      end
      if (redirect) begin
        mq.delete();
        m_fpc = redirect_pc & 32'hFFFF_FFFC;
      end
    end
  end

  // Per-cycle comparison of the main instance against the model.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      check("rst_imem_req", imem_req, 32'h0);
      check("rst_out_valid", out_valid, 32'h0);
      check("rst_out_pc4", out_pc4, 32'h0);
      check("rst_out_instr", out_instr, 32'h0);
    end else begin
      e_valid = (mq.size() != 0);
      e_head  = e_valid ? mq[0] : 64'h0;
      e_req   = m_busy || ((mq.size() < 2) && !redirect);
      e_addr  = m_busy ? m_addr : m_fpc;
      check("out_valid", out_valid, e_valid);
      check("out_pc4", out_pc4, e_head[63:32]);
      check("out_instr", out_instr, e_head[31:0]);
      check("imem_req", imem_req, e_req);
      if (e_req) check("imem_addr", imem_addr, e_addr);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    run(3);
    check("lit_rst_req", imem_req, 32'h0);
    check("lit_rst_valid", out_valid, 32'h0);
    check("lit_rst_pc4", out_pc4, 32'h0);
    check("lit_rst_instr", out_instr, 32'h0);

    // Straight-line fetch with one-cycle memory latency.
    rst = 1'b0;
    #1;
    check("lit_first_req", imem_req, 32'h1);
    check("lit_first_addr", imem_addr, 32'h0);
    check("lit2_first_addr", imem_addr2, 32'hFFFF_FFFC);
    run(1);
    check("lit_wait_addr", imem_addr, 32'h0);
    run(1);
    check("lit_valid1", out_valid, 32'h1);
    check("lit_pc4_1", out_pc4, 32'h4);
    check("lit_instr1", out_instr, 32'hFFFF_FFFF);
    check("lit_addr4", imem_addr, 32'h4);
    check("lit2_valid", out_valid2, 32'h1);
    check("lit2_pc4_wrap", out_pc42, 32'h0);
    check("lit2_instr", out_instr2, 32'h0000_0003);
    check("lit2_second_addr", imem_addr2, 32'h0);
    run(2);
    check("lit_pc4_2", out_pc4, 32'h8);
    check("lit_instr2", out_instr, 32'hFFFF_FFFB);
    check("lit_addr8", imem_addr, 32'h8);
    run(2);
    check("lit_pc4_3", out_pc4, 32'hC);
    check("lit_instr3", out_instr, 32'hFFFF_FFF7);

    // Six stalled cycles: buffer fills, requests stop, head held.
    stall = 1'b1;
    run(3);
    check("lit_full_noreq", imem_req, 32'h0);
    check("lit_hold_pc4", out_pc4, 32'hC);
    check("lit_hold_instr", out_instr, 32'hFFFF_FFF7);
    run(3);
    stall = 1'b0;
    check("lit_hold_pc4b", out_pc4, 32'hC);
    run(1);
    check("lit_drain_pc4", out_pc4, 32'h10);
    check("lit_drain_instr", out_instr, 32'hFFFF_FFF3);
    run(2);
    check("lit_next_pc4", out_pc4, 32'h14);

    // Redirect while waiting; the late data must be dropped.
    auto_mem = 1'b0;
    imem_ack = 1'b0;
    wait_req();
    run(1);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    run(1);
    redirect = 1'b0;
    #1;
    check("lit_drop_req", imem_req, 32'h1);
    check("lit_drop_valid", out_valid, 32'h0);
    run(2);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    run(1);
    imem_ack = 1'b0;
    #1;
    check("lit_redir_req", imem_req, 32'h1);
    check("lit_redir_addr", imem_addr, 32'h0000_0100);
    check("lit_redir_valid", out_valid, 32'h0);
    age      = 0;
    auto_mem = 1'b1;
    run(2);
    check("lit_redir_pc4", out_pc4, 32'h0000_0104);
    check("lit_redir_instr", out_instr, 32'hFFFF_FEFF);

    // Redirect coincident with ack and stall, buffer non-empty.
    stall    = 1'b1;
    auto_mem = 1'b0;
    imem_ack = 1'b0;
    wait_req();
    run(1);
    check("lit_coin_pre_valid", out_valid, 32'h1);
    imem_ack    = 1'b1;
    imem_rdata  = 32'h1234_5678;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    run(1);
    imem_ack = 1'b0;
    redirect = 1'b0;
    stall    = 1'b0;
    #1;
    check("lit_coin_valid", out_valid, 32'h0);
    check("lit_coin_req", imem_req, 32'h1);
    check("lit_coin_addr", imem_addr, 32'h0000_0200);
    age      = 0;
    auto_mem = 1'b1;
    run(2);
    check("lit_coin_pc4", out_pc4, 32'h0000_0204);
    check("lit_coin_instr", out_instr, 32'hFFFF_FDFF);

    // Reset while waiting, stray ack right after release.
    auto_mem = 1'b0;
    imem_ack = 1'b0;
    wait_req();
    run(1);
    rst = 1'b1;
    #1;
    check("lit_arst_req", imem_req, 32'h0);
    check("lit_arst_valid", out_valid, 32'h0);
    run(1);
    rst        = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hCAFE_F00D;
    #1;
    check("lit_restart_req", imem_req, 32'h1);
    check("lit_restart_addr", imem_addr, 32'h0);
    run(1);
    imem_ack = 1'b0;
    #1;
    check("lit_stray_valid", out_valid, 32'h0);
    check("lit_stray_addr", imem_addr, 32'h0);
    age      = 1;
    auto_mem = 1'b1;
    run(1);
    check("lit_restart_valid", out_valid, 32'h1);
    check("lit_restart_pc4", out_pc4, 32'h4);
    check("lit_restart_instr", out_instr, 32'hFFFF_FFFF);
    run(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
